// File: rtl/cpu_fetch_queue_pkg.sv
// Shared defaults and small helpers for the instruction prefetch queue and its FIFOs.
package cpu_fetch_queue_pkg;

  localparam int FETCH_XLEN            = 32;
  localparam int FETCH_QUEUE_DEPTH     = 4;
  localparam int FETCH_MAX_OUTSTANDING = 2;
  localparam int FETCH_PC_STEP         = 4;

  // Fate of a read beat presented on the R channel this cycle.
  typedef enum logic [1:0] {
    BEAT_NONE = 2'd0,
    BEAT_KEEP = 2'd1,
    BEAT_DROP = 2'd2
  } beat_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cpu_fetch_queue_sync_fifo.sv
// Synchronous FIFO with clear, occupancy count and a registered head entry view.
module sync_fifo
  import cpu_fetch_queue_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PW    = ptr_width(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_s     = pop && !empty;
  assign push_s    = push && (!full || pop_s);
  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction prefetch unit: pipelined AXI-Lite reads into a PC-tagged FIFO, with
// redirect flushing and silent discard of responses that belong to the old stream.
module cpu_fetch_queue
  import cpu_fetch_queue_pkg::*;
#(
  parameter int              XLEN            = FETCH_XLEN,
  parameter int              DEPTH           = FETCH_QUEUE_DEPTH,
  parameter int              MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}}
) (
  input  logic            i_Clock,
  input  logic            w_Reset,
  input  logic            i_Enable_Fetch,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_Redirect_PC,
  input  logic            i_Instruction_Ready,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_Instruction_PC,
  output logic            o_Instruction_Valid,
  output logic [XLEN-1:0] o_Fetch_PC,
  output logic            o_Idle,
  output logic [XLEN-1:0] s_axil_araddr,
  output logic            s_axil_arvalid,
  input  logic            s_axil_arready,
  input  logic [XLEN-1:0] s_axil_rdata,
  input  logic            s_axil_rvalid,
  output logic            s_axil_rready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = CW + IW;

  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   araddr_r;
  logic              arvalid_r;
  logic              stale_ar_r;
  logic [IW-1:0]     drop_r;
  logic [IW-1:0]     inflight_s;
  logic [IW-1:0]     inflight_next_s;
  logic [XLEN-1:0]   pc_after_s;
  logic [SW-1:0]     credit_s;
  logic              ar_fire_s;
  logic              ar_pending_s;
  logic              r_fire_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  beat_e             beat_s;
  logic [2*XLEN-1:0] instr_head_s;
  logic [XLEN-1:0]   tag_head_s;
  logic [CW-1:0]     instr_count_s;
  logic              instr_empty_s;
  logic              instr_full_s;
  logic              tag_empty_s;
  logic              tag_full_s;
  logic              unused_full_s;

  // The tag queue occupancy is the in-flight count; an R beat with nothing in flight is ignored.
  assign ar_fire_s       = arvalid_r && s_axil_arready;
  assign ar_pending_s    = arvalid_r && !s_axil_arready;
  assign r_fire_s        = s_axil_rvalid && !tag_empty_s;
  assign inflight_next_s = inflight_s + IW'(ar_fire_s) - IW'(r_fire_s);
  assign pc_after_s      = (ar_fire_s && !stale_ar_r) ? fetch_pc_r + XLEN'(FETCH_PC_STEP) : fetch_pc_r;
  assign credit_s        = SW'(instr_count_s) + SW'(inflight_s) + SW'(ar_fire_s);

  // An AR handshaking this cycle frees the channel, so the next request can follow back-to-back.
  assign issue_s = i_Enable_Fetch && !i_Redirect && (!arvalid_r || ar_fire_s) &&
                   (inflight_next_s < IW'(MAX_OUTSTANDING)) && (credit_s < SW'(DEPTH));

  always_comb begin
    beat_s = BEAT_NONE;
    if (!r_fire_s) begin
      beat_s = BEAT_NONE;
    end else if (i_Redirect || (drop_r != {IW{1'b0}})) begin
      beat_s = BEAT_DROP;
    end else begin
      beat_s = BEAT_KEEP;
    end
  end

  assign push_s = (beat_s == BEAT_KEEP);
  assign pop_s  = !instr_empty_s && i_Instruction_Ready && !i_Redirect;

  always_ff @(posedge i_Clock) begin
    if (w_Reset) begin
      fetch_pc_r <= RESET_PC;
      araddr_r   <= {XLEN{1'b0}};
      arvalid_r  <= 1'b0;
      stale_ar_r <= 1'b0;
      drop_r     <= {IW{1'b0}};
    end else begin
      if (i_Redirect) begin
        // Everything in flight, plus an AR still waiting for arready, belongs to the old stream.
        fetch_pc_r <= i_Redirect_PC;
        drop_r     <= inflight_next_s + IW'(ar_pending_s);
        stale_ar_r <= ar_pending_s;
      end else begin
        fetch_pc_r <= pc_after_s;
        drop_r     <= (beat_s == BEAT_DROP) ? drop_r - IW'(1) : drop_r;
        stale_ar_r <= ar_fire_s ? 1'b0 : stale_ar_r;
      end
      if (issue_s) begin
        arvalid_r <= 1'b1;
        araddr_r  <= pc_after_s;
      end else if (ar_fire_s) begin
        arvalid_r <= 1'b0;
      end else begin
        arvalid_r <= arvalid_r;
      end
    end
  end

  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_instr_fifo (
    .clock     (i_Clock),
    .reset     (w_Reset),
    .clear     (i_Redirect),
    .push      (push_s),
    .push_data ({tag_head_s, s_axil_rdata}),
    .pop       (pop_s),
    .head_data (instr_head_s),
    .count     (instr_count_s),
    .full      (instr_full_s),
    .empty     (instr_empty_s)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clock     (i_Clock),
    .reset     (w_Reset),
    .clear     (1'b0),
    .push      (ar_fire_s),
    .push_data (araddr_r),
    .pop       (r_fire_s),
    .head_data (tag_head_s),
    .count     (inflight_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

  assign unused_full_s       = instr_full_s | tag_full_s;
  assign o_Instruction_Valid = !instr_empty_s;
  assign o_Instruction       = instr_empty_s ? {XLEN{1'b0}} : instr_head_s[XLEN-1:0];
  assign o_Instruction_PC    = instr_empty_s ? {XLEN{1'b0}} : instr_head_s[2*XLEN-1:XLEN];
  assign o_Fetch_PC          = fetch_pc_r;
  assign o_Idle              = instr_empty_s && tag_empty_s && !arvalid_r;
  assign s_axil_araddr       = araddr_r;
  assign s_axil_arvalid      = arvalid_r;
  assign s_axil_rready       = 1'b1;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Scoreboard bench: the expected consumer stream is contiguous words from the last redirect/reset PC.
module tb_cpu_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

  logic        i_Clock = 1'b0;
  logic        w_Reset, i_Enable_Fetch, i_Redirect, i_Instruction_Ready;
  logic [31:0] i_Redirect_PC;
  logic [31:0] o_Instruction, o_Instruction_PC, o_Fetch_PC, s_axil_araddr, s_axil_rdata;
  logic        o_Instruction_Valid, o_Idle, s_axil_arvalid, s_axil_arready, s_axil_rvalid, s_axil_rready;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  exp_t        exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] rq[$];
  logic [31:0] ar_log[$];
  int          ar_mode = 1;
  bit          hold_beats = 1'b0;
  int          rv_pct = 100;

  always #5 i_Clock = ~i_Clock;

  cpu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .i_Clock(i_Clock), .w_Reset(w_Reset), .i_Enable_Fetch(i_Enable_Fetch),
    .i_Redirect(i_Redirect), .i_Redirect_PC(i_Redirect_PC),
    .i_Instruction_Ready(i_Instruction_Ready), .o_Instruction(o_Instruction),
    .o_Instruction_PC(o_Instruction_PC), .o_Instruction_Valid(o_Instruction_Valid),
    .o_Fetch_PC(o_Fetch_PC), .o_Idle(o_Idle), .s_axil_araddr(s_axil_araddr),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{gen_pc, mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    topup();
  endtask

  task automatic cyc();
    @(posedge i_Clock);
    #1;
    topup();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    i_Redirect    = 1'b1;
    i_Redirect_PC = pc;
    restart_stream(pc);
    cyc();
    i_Redirect = 1'b0;
  endtask

  task automatic do_reset();
    i_Enable_Fetch = 1'b0;
    hold_beats     = 1'b0;
    w_Reset        = 1'b1;
    restart_stream(RESET_PC);
    repeat (4) cyc();
    w_Reset = 1'b0;
  endtask

  // Memory model: random or fixed arready, in-order R beats from the accepted-address queue.
  initial begin
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    s_axil_rdata   = 32'd0;
    forever begin
      @(posedge i_Clock);
      #1;
      case (ar_mode)
        0:       s_axil_arready = ($urandom_range(0, 99) < 60);
        1:       s_axil_arready = 1'b1;
        default: s_axil_arready = 1'b0;
      endcase
      if (rq.size() > 0 && !hold_beats && ($urandom_range(0, 99) < rv_pct)) begin
        s_axil_rvalid = 1'b1;
        s_axil_rdata  = mem_word(rq.pop_front());
      end else begin
        s_axil_rvalid = 1'b0;
        s_axil_rdata  = $urandom;
      end
    end
  end

  // AR channel observer: logs handshakes, checks AR stability and the outstanding limit.
  initial begin
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    forever begin
      @(negedge i_Clock);
      if (!w_Reset) begin
        if (prev_hold) begin
          check("ar_held_valid", 32'(s_axil_arvalid), 32'd1);
          check("ar_held_addr", s_axil_araddr, prev_addr);
        end
        if (s_axil_arvalid && s_axil_arready) begin
          rq.push_back(s_axil_araddr);
          ar_log.push_back(s_axil_araddr);
        end
        check("outstanding_limit", 32'(rq.size() <= MAXO), 32'd1);
      end
      prev_hold = !w_Reset && s_axil_arvalid && !s_axil_arready;
      prev_addr = s_axil_araddr;
    end
  end

  // Scoreboard monitor: every instruction the consumer takes must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_Clock);
      if (!w_Reset && o_Instruction_Valid && i_Instruction_Ready && !i_Redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", o_Instruction_PC, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", o_Instruction_PC, e.pc);
          check("sb_data", o_Instruction, e.word);
        end
      end
    end
  end

  initial begin
    int          c;
    int          p0;
    logic [31:0] a;
    w_Reset = 1'b1; i_Enable_Fetch = 1'b0; i_Redirect = 1'b0;
    i_Redirect_PC = 32'd0; i_Instruction_Ready = 1'b0;
    restart_stream(RESET_PC);
    repeat (3) cyc();
    check("rst_valid", 32'(o_Instruction_Valid), 32'd0);
    check("rst_arvalid", 32'(s_axil_arvalid), 32'd0);
    check("rst_idle", 32'(o_Idle), 32'd1);
    check("rst_instr", o_Instruction, 32'd0);
    check("rst_instr_pc", o_Instruction_PC, 32'd0);
    check("rst_fetch_pc", o_Fetch_PC, RESET_PC);
    w_Reset = 1'b0;
    repeat (3) cyc();
    check("idle_disabled", 32'(o_Idle), 32'd1);
    check("no_ar_disabled", 32'(ar_log.size()), 32'd0);

    // Zero-wait memory: one instruction per cycle once the first word lands.
    ar_mode = 1; rv_pct = 100; i_Instruction_Ready = 1'b1; i_Enable_Fetch = 1'b1;
    for (int i = 0; i < 20 && !o_Instruction_Valid; i++) cyc();
    check("t1_first_valid", 32'(o_Instruction_Valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t1_throughput", 32'(o_Instruction_Valid), 32'd1);
    end

    // Consumer stalled: the credit limit allows exactly DEPTH reads.
    do_reset();
    i_Instruction_Ready = 1'b0; i_Enable_Fetch = 1'b1;
    c = ar_log.size();
    repeat (30) cyc();
    check("t2_ar_count", 32'(ar_log.size() - c), 32'(DEPTH));
    check("t2_no_fifth_ar", 32'(s_axil_arvalid), 32'd0);
    i_Instruction_Ready = 1'b1;
    c = ar_log.size();
    for (int i = 0; i < 50 && ar_log.size() <= c; i++) cyc();
    check("t2_resume_timeout", 32'(ar_log.size() > c), 32'd1);
    if (ar_log.size() > c) check("t2_resume_pc", ar_log[c], 32'h10);

    // Redirect while an AR waits for arready.
    do_reset();
    ar_mode = 2; i_Enable_Fetch = 1'b1;
    for (int i = 0; i < 10 && !s_axil_arvalid; i++) cyc();
    check("t3_arvalid_timeout", 32'(s_axil_arvalid), 32'd1);
    a = s_axil_araddr;
    check("t3_first_addr", a, RESET_PC);
    cyc();
    do_redirect(32'h100);
    cyc();
    check("t3_addr_held", s_axil_araddr, a);
    check("t3_fetch_pc", o_Fetch_PC, 32'h100);
    ar_mode = 1;
    p0 = pops;
    repeat (20) cyc();
    check("t3_progress", 32'(pops - p0 >= 4), 32'd1);

    // Two reads in flight when redirected: both beats must vanish.
    do_reset();
    hold_beats = 1'b1; i_Enable_Fetch = 1'b1;
    c = ar_log.size();
    for (int i = 0; i < 10 && ar_log.size() < c + 2; i++) cyc();
    check("t4_two_ar", 32'(ar_log.size() - c), 32'd2);
    cyc();
    do_redirect(32'h200);
    hold_beats = 1'b0;
    p0 = pops;
    repeat (20) cyc();
    check("t4_progress", 32'(pops - p0 >= 4), 32'd1);

    // Reset with reads outstanding; their late beats must be ignored.
    do_reset();
    hold_beats = 1'b1; i_Enable_Fetch = 1'b1;
    c = ar_log.size();
    for (int i = 0; i < 10 && ar_log.size() < c + 2; i++) cyc();
    cyc();
    i_Enable_Fetch = 1'b0;
    w_Reset = 1'b1;
    restart_stream(RESET_PC);
    cyc();
    w_Reset = 1'b0;
    hold_beats = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t6_valid_low", 32'(o_Instruction_Valid), 32'd0);
      check("t6_idle", 32'(o_Idle), 32'd1);
    end
    check("t6_beats_drained", 32'(rq.size()), 32'd0);
    i_Enable_Fetch = 1'b1;
    c = ar_log.size();
    for (int i = 0; i < 10 && ar_log.size() <= c; i++) cyc();
    check("t6_ar_timeout", 32'(ar_log.size() > c), 32'd1);
    if (ar_log.size() > c) check("t6_first_pc", ar_log[c], RESET_PC);

    // Randomized traffic with random redirects, including near the address wrap.
    ar_mode = 0; rv_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      i_Enable_Fetch      = ($urandom_range(0, 99) < 90);
      i_Instruction_Ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 3) == 0) do_redirect(32'hFFFF_FFF4);
        else do_redirect(32'h0000_1000 + ($urandom_range(0, 255) << 2));
      end else begin
        cyc();
      end
    end

    i_Enable_Fetch = 1'b1; i_Instruction_Ready = 1'b1; ar_mode = 1; rv_pct = 100;
    repeat (5) cyc();
    p0 = pops;
    repeat (30) cyc();
    check("final_progress", 32'(pops - p0 >= 20), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
